// File: rtl/vmm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vmm_pkg
//  Description : Shared definitions for the VMM complex datapath: default
//                operand/result widths, a wide complex-sample struct and the
//                round-half-up / saturate helper used at result output.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vmm_pkg;

  // Default widths of the complex MAC datapath.
  localparam int DEF_A_W   = 16;
  localparam int DEF_B_W   = 10;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 9;

  // Widest accumulator the helper function supports.
  localparam int WIDE_W = 64;

  // Complex sample held at the widest supported width. Narrower samples are
  // sign-extended into it.
  typedef struct packed {
    logic signed [WIDE_W-1:0] re;
    logic signed [WIDE_W-1:0] im;
  } cplx_wide_t;

  // One rounded/saturated component plus its saturation flag.
  typedef struct packed {
    logic                     sat;
    logic signed [WIDE_W-1:0] val;
  } rs_result_t;

  // Round half-up by 'shift' bits, then clamp to a signed out_w-bit range.
  // Work is done one bit wider than the input so the rounding increment can
  // never wrap.
  function automatic rs_result_t round_sat(input logic signed [WIDE_W-1:0] val,
                                           input int shift,
                                           input int out_w);
    rs_result_t            res;
    logic signed [WIDE_W:0] one;
    logic signed [WIDE_W:0] r;
    logic signed [WIDE_W:0] hi;
    logic signed [WIDE_W:0] lo;
    one = (WIDE_W+1)'(1);
    r   = (WIDE_W+1)'(val);
    if (shift > 0) begin
      r = r + (one <<< (shift - 1));
    end
    r  = r >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -(one <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = WIDE_W'(r);
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = WIDE_W'(hi);
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = WIDE_W'(lo);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cplx_prod_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cplx_prod_stage
//  Description : Two-stage complex product. S1 registers the four partial
//                products, S2 registers re/im sums with optional conj(b).
//  Ports       : CLK, rst          - clock, async active-high reset
//                en                - advance both stages (low = hold)
//                in_valid/in_last/conj_b, a_re/a_im, b_re/b_im - input beat
//                s2_valid/s2_last, s2_re/s2_im - registered complex product
//  Revision    : 1.0 - initial release
// ============================================================================
module cplx_prod_stage
  import vmm_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   conj_b,
  input  logic signed [A_W-1:0]  a_re,
  input  logic signed [A_W-1:0]  a_im,
  input  logic signed [B_W-1:0]  b_re,
  input  logic signed [B_W-1:0]  b_im,
  output logic                   s2_valid,
  output logic                   s2_last,
  output logic signed [A_W+B_W:0] s2_re,
  output logic signed [A_W+B_W:0] s2_im
);

  localparam int P_W = A_W + B_W;
  localparam int S_W = P_W + 1;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_last_q,  s1_last_d;
  logic                  s1_conj_q,  s1_conj_d;
  logic signed [P_W-1:0] rr_q, rr_d;
  logic signed [P_W-1:0] ii_q, ii_d;
  logic signed [P_W-1:0] ri_q, ri_d;
  logic signed [P_W-1:0] ir_q, ir_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_last_q,  s2_last_d;
  logic signed [S_W-1:0] s2_re_q, s2_re_d;
  logic signed [S_W-1:0] s2_im_q, s2_im_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_conj_d  = s1_conj_q;
    rr_d       = rr_q;
    ii_d       = ii_q;
    ri_d       = ri_q;
    ir_d       = ir_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_re_d    = s2_re_q;
    s2_im_d    = s2_im_q;
    if (en) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      // Data registers only load on a real beat; bubbles leave them alone.
      if (in_valid) begin
        s1_last_d = in_last;
        s1_conj_d = conj_b;
        rr_d      = P_W'(a_re) * P_W'(b_re);
        ii_d      = P_W'(a_im) * P_W'(b_im);
        ri_d      = P_W'(a_re) * P_W'(b_im);
        ir_d      = P_W'(a_im) * P_W'(b_re);
      end
      if (s1_valid_q) begin
        s2_last_d = s1_last_q;
        // conj(b) flips the sign of b_im, i.e. of the ii and ri terms.
        if (s1_conj_q) begin
          s2_re_d = S_W'(rr_q) + S_W'(ii_q);
          s2_im_d = S_W'(ir_q) - S_W'(ri_q);
        end else begin
          s2_re_d = S_W'(rr_q) - S_W'(ii_q);
          s2_im_d = S_W'(ir_q) + S_W'(ri_q);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_conj_q  <= 1'b0;
      rr_q       <= '0;
      ii_q       <= '0;
      ri_q       <= '0;
      ir_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_conj_q  <= s1_conj_d;
      rr_q       <= rr_d;
      ii_q       <= ii_d;
      ri_q       <= ri_d;
      ir_q       <= ir_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
    end
  end

  assign s2_valid = s2_valid_q;
  assign s2_last  = s2_last_q;
  assign s2_re    = s2_re_q;
  assign s2_im    = s2_im_q;

endmodule
`default_nettype wire

// File: rtl/complex_mac_stream.sv
`default_nettype none
// ============================================================================
//  Module      : complex_mac_stream
//  Description : Streaming complex multiply-accumulate. Accumulates a*b (or
//                a*conj(b)) over a vector ended by in_last and emits one
//                rounded, saturated complex result per vector.
//  Ports       : CLK, rst                 - clock, async active-high reset
//                in_valid/in_ready        - input beat handshake
//                in_last, conj_b          - per-beat vector end / conj(b)
//                a_re/a_im, b_re/b_im     - complex operands
//                out_valid/out_ready      - result handshake
//                out_re/out_im, out_sat   - result and saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module complex_mac_stream
  import vmm_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic                    conj_b,
  input  logic signed [A_W-1:0]   a_re,
  input  logic signed [A_W-1:0]   a_im,
  input  logic signed [B_W-1:0]   b_re,
  input  logic signed [B_W-1:0]   b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    out_sat
);

  localparam int S_W = A_W + B_W + 1;

  logic                    stall;
  logic                    s2_valid;
  logic                    s2_last;
  logic signed [S_W-1:0]   s2_re;
  logic signed [S_W-1:0]   s2_im;

  logic                    s3_valid_q, s3_valid_d;
  logic signed [ACC_W-1:0] s3_re_q, s3_re_d;
  logic signed [ACC_W-1:0] s3_im_q, s3_im_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_re_q, out_re_d;
  logic signed [OUT_W-1:0] out_im_q, out_im_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;
  cplx_wide_t              s3_wide;
  rs_result_t              rs_re;
  rs_result_t              rs_im;

  // A pending unaccepted result freezes the whole pipe, so nothing in
  // flight can be dropped or overtaken.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  cplx_prod_stage #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_prod (
    .CLK      (CLK),
    .rst      (rst),
    .en       (~stall),
    .in_valid (in_valid),
    .in_last  (in_last),
    .conj_b   (conj_b),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .s2_valid (s2_valid),
    .s2_last  (s2_last),
    .s2_re    (s2_re),
    .s2_im    (s2_im)
  );

  // Accumulator is modulo 2^ACC_W by construction of the fixed-width add.
  assign sum_re = acc_re_q + ACC_W'(s2_re);
  assign sum_im = acc_im_q + ACC_W'(s2_im);

  assign s3_wide.re = WIDE_W'(s3_re_q);
  assign s3_wide.im = WIDE_W'(s3_im_q);
  assign rs_re      = round_sat(s3_wide.re, SHIFT, OUT_W);
  assign rs_im      = round_sat(s3_wide.im, SHIFT, OUT_W);

  always_comb begin
    s3_valid_d  = s3_valid_q;
    s3_re_d     = s3_re_q;
    s3_im_d     = s3_im_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_sat_d   = out_sat_q;
    if (!stall) begin
      // S3 only ever holds completed vector sums.
      s3_valid_d = s2_valid & s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          s3_re_d  = sum_re;
          s3_im_d  = sum_im;
          acc_re_d = '0;
          acc_im_d = '0;
        end else begin
          acc_re_d = sum_re;
          acc_im_d = sum_im;
        end
      end
      // Not stalled means any current result is being accepted now, so
      // out_valid simply follows S3.
      out_valid_d = s3_valid_q;
      if (s3_valid_q) begin
        out_re_d  = OUT_W'(rs_re.val);
        out_im_d  = OUT_W'(rs_im.val);
        out_sat_d = rs_re.sat | rs_im.sat;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      s3_valid_q  <= 1'b0;
      s3_re_q     <= '0;
      s3_im_q     <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      s3_valid_q  <= s3_valid_d;
      s3_re_q     <= s3_re_d;
      s3_im_q     <= s3_im_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire
